// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream boot loader for the instruction memory.
// Frame is count N, 4N little-endian data bytes, then an XOR checksum byte.
module imem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 32,
  parameter int MAX_WORDS  = MEM_BYTES / 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            word_count
);

  localparam int CW = $clog2(MEM_BYTES) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [7:0]            word_count_q, word_count_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            acc_q, acc_d;

  logic       xfer;
  logic [9:0] cnt_inc;
  logic [9:0] frame_bytes;

  assign xfer        = in_valid & in_ready_q;
  assign cnt_inc     = 10'(cnt_q) + 10'd1;
  assign frame_bytes = {word_count_q, 2'b00};

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;
    word_count_d = word_count_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_HDR;
          done_d      = 1'b0;
          error_d     = 1'b0;
          cpu_reset_d = 1'b1;
        end
      end
      S_HDR: begin
        if (xfer) begin
          word_count_d = in_data;
          if (in_data == 8'd0 || 32'(in_data) > MAX_WORDS) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
            cnt_d   = '0;
            acc_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ADDR_WIDTH'(cnt_q);
          wr_data_d = in_data;
          acc_d     = acc_q ^ in_data;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_inc == frame_bytes) state_d = S_CSUM;
        end
      end
      S_CSUM: begin
        // Checksum byte is compared only; it never reaches memory.
        if (xfer) begin
          if (in_data == acc_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      word_count_q <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
      word_count_q <= word_count_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;
  assign word_count = word_count_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream boot loader that writes program images into the byte-addressed instruction memory.
- It is the write side of the instruction-memory interface; the fetch path is the read side.
- Receives a framed image (count, little-endian words, checksum) over a valid/ready byte port.
- Emits one byte write per cycle into the memory array.
- Holds the CPU in reset until the image loads successfully.

Parameters:
ADDR_WIDTH, 32, width of wr_addr; matches the PC / memory address width.
MEM_BYTES, 32, instruction memory size in bytes; must be a multiple of 4.
MAX_WORDS, MEM_BYTES/4, largest legal word count in a frame.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
in_valid  input  1  in_data holds a valid byte.
in_data  input  8  stream byte.
in_ready  output  1  loader accepts a byte this cycle; transfer = in_valid & in_ready at the clock edge.
wr_en  output  1  byte write strobe to instruction memory.
wr_addr  output  ADDR_WIDTH  byte address of the write.
wr_data  output  8  byte to write.
cpu_reset  output  1  active-high hold of the processor and fetch path.
done  output  1  image loaded and checksum matched.
error  output  1  bad word count or checksum mismatch.
word_count  output  8  N latched from the header.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE.
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - cpu_reset=1, done=0, error=0, word_count=0.
  - Byte counter and checksum accumulator cleared.
  - Applies immediately, including mid-frame; writes already issued are not undone.
- States: IDLE, HDR, DATA, CSUM, DONE, ERR.
- in_ready is 1 only in HDR, DATA and CSUM, as a registered decode of the state.
- start behaviour:
  - IDLE/DONE/ERR + start -> HDR; clears done and error, sets cpu_reset=1.
  - start is ignored in HDR, DATA and CSUM.
- HDR, on transfer:
  - Latch word_count = in_data.
  - If N==0 or N>MAX_WORDS -> ERR; no writes are issued.
  - Otherwise -> DATA; byte counter = 0, checksum accumulator = 0.
- DATA, on each transfer:
  - Next cycle: wr_en=1, wr_addr=byte counter (zero-extended), wr_data=in_data. Write latency is exactly 1 cycle after acceptance.
  - wr_en=0 in any cycle without a preceding transfer. Stalls and in_valid gaps never duplicate or drop writes.
  - Accumulator ^= in_data; counter += 1.
  - Byte order is little-endian: word k occupies addresses 4k..4k+3, lowest-significance byte first.
  - When the counter reaches 4N on this transfer -> CSUM.
- CSUM, on transfer:
  - in_data == accumulator -> DONE.
  - Otherwise -> ERR.
  - The checksum byte is never written to memory.
- DONE: done=1, cpu_reset=0, in_ready=0.
- ERR: error=1, cpu_reset=1, in_ready=0.
- done and error are never both 1.
- Counter width is clog2(MEM_BYTES)+1; it cannot wrap because N≤MAX_WORDS.
- The final data byte's wr_en pulse coincides with the first CSUM cycle.
- cpu_reset deasserts in the cycle after the checksum is accepted. The last write has completed before release.
- Bytes presented while in_ready=0 are ignored and are not consumed.

Test Plan:
1. Nominal load:
   - Stimulus: start; stream 02, 33 03 94 01, 93 03 39 00, then checksum 0C, with in_valid held high.
   - Required: 8 wr_en pulses at addresses 0..7 with data 33,03,94,01,93,03,39,00; each pulse 1 cycle after acceptance; word_count=2; then done=1, cpu_reset=0, error=0.
2. Bad checksum:
   - Stimulus: same frame with checksum 0D.
   - Required: all 8 writes still occur; error=1, done=0, cpu_reset stays 1.
3. Illegal count:
   - Stimulus: header 00; separately, header 09 with MEM_BYTES=32.
   - Required: ERR after the header byte; zero wr_en pulses; in_ready=0 afterwards.
4. Backpressure and gaps:
   - Stimulus: nominal frame with in_valid toggled randomly, including 3-cycle gaps.
   - Required: exactly 8 writes, same addresses and data as scenario 1, no duplicates; done=1.
5. Reset mid-frame:
   - Stimulus: assert reset after 3 data bytes.
   - Required: in_ready=0, wr_en=0, cpu_reset=1 immediately (asynchronously); after release, state is IDLE. A following start plus the full frame loads correctly.
6. Full-size load and reload:
   - Stimulus: N=8 with 32 bytes 00..1F, checksum 00; then start again from DONE with scenario 1's frame.
   - Required: last write at address 31 with data 1F, done=1. On restart, done clears and cpu_reset=1 the cycle after start; after the reload, done=1.
